can_cmd_dispatcher: RTL and testbench
=====================================

// Module: can_cmd_dispatcher
// PURPOSE
//  Command layer directly downstream of can_data_link's RX port and upstream of its TX port.
//  Consumes each received 8-byte CAN payload and validates it (XOR checksum, command, address).
//  Executes register write/read/status commands on the PMSM control register bus.
//  Returns exactly one 8-byte response frame per accepted command through the TX handshake.
// PARAMETERS
//  NUM_REGS    8       number of addressable 32-bit control registers (addr 0..NUM_REGS-1)
//  ADDR_W      3       width of reg_addr_out; must satisfy 2**ADDR_W >= NUM_REGS
//  TX_TIMEOUT  50000   sys_clk cycles to wait for tx_ready_in before dropping a response
// PORTS
//  sys_clk                       in   1   system clock; sole clock of the block
//  reset_n                       in   1   asynchronous active-low reset
//  system_initilization_done_in  in   1   high = system ready; frames before this are discarded
//  rx_dw1r_in                    in   32  received bytes 0..3; byte0 = [31:24]
//  rx_dw2r_in                    in   32  received bytes 4..7; byte4 = [31:24]
//  rx_valid_in                   in   1   RX frame valid (from can_data_link rx_valid_out)
//  rx_ready_out                  out  1   dispatcher can accept a frame
//  tx_dw1r_out                   out  32  response bytes 0..3
//  tx_dw2r_out                   out  32  response bytes 4..7
//  tx_valid_out                  out  1   response valid; held until tx_ready_in
//  tx_ready_in                   in   1   can_data_link accepted the response
//  reg_wr_en_out                 out  1   one-cycle register write strobe
//  reg_rd_en_out                 out  1   one-cycle register read strobe
//  reg_addr_out                  out  ADDR_W  register address for write/read
//  reg_wr_data_out               out  32  register write data
//  reg_rd_data_in                in   32  read data, valid 1 cycle after reg_rd_en_out
//  ok_cnt_out / err_cnt_out      out  16  saturating good / bad frame counters
//  busy_out                      out  1   high in every state except IDLE
// BEHAVIOUR
//  Request frame: b0 = cmd, b1 = addr, b2..b5 = data (b2 = MSB), b6 = seq, b7 = XOR(b0..b6).
//  Commands: 0x01 write register, 0x02 read register, 0x03 status query.
//  Reset: all outputs 0, except rx_ready_out = 0 until the first cycle in IDLE; counters 0; FSM in IDLE.
//  FSM states: IDLE -> CHECK -> EXEC -> RESP -> TX_WAIT -> IDLE.
//  IDLE: rx_ready_out = 1. Frame accepted on rx_valid_in & rx_ready_out; it is latched and
//    rx_ready_out drops on the next cycle.
//    If system_initilization_done_in = 0: frame discarded, stay in IDLE, no response, no count.
//    Otherwise go to CHECK.
//  CHECK (1 cycle): status is evaluated with precedence checksum > cmd > addr:
//    0x01 bad checksum; 0x03 unknown cmd; 0x02 addr >= NUM_REGS (cmd 1/2 only); else 0x00.
//  EXEC (1 cycle), only when status = 0x00:
//    cmd 1: reg_wr_en_out = 1 with addr/data.
//    cmd 2: reg_rd_en_out = 1 with addr.
//  RESP (1 cycle): response is built and registered:
//    b0 = cmd | 0x80; b1 = addr; b6 = seq; b7 = status.
//    b2..b5 = write data (cmd1), reg_rd_data_in (cmd2), {ok_cnt, err_cnt} as sampled in CHECK (cmd3);
//    0 on any error.
//    tx_valid_out rises on the same edge: 3 edges after the accept edge.
//  TX_WAIT: tx_valid_out and data held stable.
//    On tx_ready_in: tx_valid_out clears next edge, go to IDLE.
//    On TX_TIMEOUT cycles without tx_ready_in: drop the response, err_cnt += 1, go to IDLE.
//  Counters: ok_cnt += 1 in RESP when status = 0x00; err_cnt += 1 in RESP when status != 0x00.
//    Both saturate at 0xFFFF.
//  Simultaneous tx_ready_in and timeout terminal count: tx_ready_in wins, no error.
//  rx_valid_in while busy: ignored (not accepted); can_data_link holds the frame.
//  Async reset mid-transaction: any pending response is abandoned; no partial strobe.
//  system_initilization_done_in falling while busy: current transaction completes normally.
// STRUCTURE
//  Package can_cmd_pkg:
//    typedef enum state_t {IDLE, CHECK, EXEC, RESP, TX_WAIT}
//    CMD_WRITE = 8'h01, CMD_READ = 8'h02, CMD_STATUS = 8'h03, RESP_FLAG = 8'h80
//    ST_OK = 8'h00, ST_BAD_CSUM = 8'h01, ST_BAD_ADDR = 8'h02, ST_BAD_CMD = 8'h03
//  One sub-module, can_frame_checker: combinational XOR / cmd / addr check producing status.
//  FSM, counters and timeout counter stay in the top module.
// TESTING
//  1 Write {01,02,00,00,12,34,05,csum}
//      -> reg_wr_en 1 cycle, addr 2, data 0x00001234;
//      -> response 81 02 00 00 12 34 05 00; ok_cnt = 1.
//  2 Read addr 2, reg_rd_data_in = 0xDEADBEEF
//      -> reg_rd_en pulse; response 82 02 DE AD BE EF seq 00;
//      -> tx_valid_out 3 edges after accept.
//  3 Bad checksum (b7 XOR 0x01)
//      -> no reg strobe; response 81 02 00 00 00 00 seq 01; err_cnt = 1.
//  4 Errors: cmd 0x07 -> status 03; read addr 8 (NUM_REGS = 8) -> status 02;
//      3 ok + 2 err then cmd3 -> data 00 03 00 02.
//  5 Hold tx_ready_in low TX_TIMEOUT cycles
//      -> tx_valid_out drops, err_cnt += 1, next frame accepted; preload 0xFFFF -> no wrap.
//  6 Frame before system_initilization_done_in -> accepted, no response, no strobes;
//      reset_n low in TX_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/can_cmd_pkg.sv
// Shared types and constants for the CAN command dispatcher.
// The frame struct mirrors the RX word layout: {dw1, dw2} with byte0 in the MSBs.
package can_cmd_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, EXEC, RESP, TX_WAIT} state_t;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] CMD_STATUS  = 8'h03;
    localparam logic [7:0] RESP_FLAG   = 8'h80;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_CSUM = 8'h01;
    localparam logic [7:0] ST_BAD_ADDR = 8'h02;
    localparam logic [7:0] ST_BAD_CMD  = 8'h03;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  seq;
        logic [7:0]  csum;
    } can_frame_t;

    function automatic logic [7:0] frame_xor(input can_frame_t f);
        return f.cmd ^ f.addr ^ f.data[31:24] ^ f.data[23:16] ^
               f.data[15:8] ^ f.data[7:0] ^ f.seq;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/can_frame_checker.sv
// Combinational request validation; checksum errors mask command errors,
// which in turn mask address errors.
module can_frame_checker
    import can_cmd_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  can_frame_t  frame,
    input  logic        unused_tie,
    output logic [7:0]  status
);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    logic cmd_known, cmd_addressed;

    always_comb begin
        cmd_addressed = (frame.cmd == CMD_WRITE) || (frame.cmd == CMD_READ);
        cmd_known     = cmd_addressed || (frame.cmd == CMD_STATUS);
        status        = ST_OK;
        if (frame_xor(frame) != frame.csum)
            status = ST_BAD_CSUM;
        else if (!cmd_known)
            status = ST_BAD_CMD;
        else if (cmd_addressed && (frame.addr >= NUM_REGS_B))
            status = ST_BAD_ADDR;
    end

    logic unused_ok;
    assign unused_ok = unused_tie;

endmodule

// File: rtl/can_cmd_dispatcher.sv
// Validates CAN request frames, runs register write/read/status commands and
// returns one response frame per accepted command.
module can_cmd_dispatcher
    import can_cmd_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_W     = 3,
    parameter int TX_TIMEOUT = 50000
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              system_initilization_done_in,
    input  logic [31:0]       rx_dw1r_in,
    input  logic [31:0]       rx_dw2r_in,
    input  logic              rx_valid_in,
    output logic              rx_ready_out,
    output logic [31:0]       tx_dw1r_out,
    output logic [31:0]       tx_dw2r_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    output logic              reg_wr_en_out,
    output logic              reg_rd_en_out,
    output logic [ADDR_W-1:0] reg_addr_out,
    output logic [31:0]       reg_wr_data_out,
    input  logic [31:0]       reg_rd_data_in,
    output logic [15:0]       ok_cnt_out,
    output logic [15:0]       err_cnt_out,
    output logic              busy_out
);
    localparam int TMO_W = $clog2(TX_TIMEOUT + 1);

    state_t            state, nxt;
    can_frame_t        frm;
    logic [7:0]        status_c, status_q;
    logic [31:0]       snap, resp_data;
    logic [15:0]       ok_cnt, err_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rdy_q, accept, tmo_hit;

    can_frame_checker #(.NUM_REGS(NUM_REGS)) u_chk (
        .frame      (frm),
        .unused_tie (1'b0),
        .status     (status_c)
    );

    assign accept  = rx_valid_in & rdy_q;
    assign tmo_hit = (tmo_cnt == TMO_W'(TX_TIMEOUT - 1)) & ~tx_ready_in;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt           = state;
        reg_wr_en_out = 1'b0;
        reg_rd_en_out = 1'b0;
        unique case (state)
            IDLE:    if (accept && system_initilization_done_in) nxt = CHECK;
            CHECK:   nxt = EXEC;
            EXEC: begin
                nxt           = RESP;
                reg_wr_en_out = (status_q == ST_OK) && (frm.cmd == CMD_WRITE);
                reg_rd_en_out = (status_q == ST_OK) && (frm.cmd == CMD_READ);
            end
            RESP:    nxt = TX_WAIT;
            TX_WAIT: if (tx_ready_in || tmo_hit) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Status-query payload uses counters snapshotted in CHECK, before this frame counts.
    always_comb begin
        resp_data = 32'h0;
        if (status_q == ST_OK) begin
            if (frm.cmd == CMD_WRITE)     resp_data = frm.data;
            else if (frm.cmd == CMD_READ) resp_data = reg_rd_data_in;
            else                          resp_data = snap;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            frm          <= '0;
            status_q     <= ST_OK;
            snap         <= '0;
            ok_cnt       <= '0;
            err_cnt      <= '0;
            tmo_cnt      <= '0;
            rdy_q        <= 1'b0;
            tx_dw1r_out  <= '0;
            tx_dw2r_out  <= '0;
            tx_valid_out <= 1'b0;
        end else begin
            rdy_q <= (nxt == IDLE);
            if (state == IDLE && accept && system_initilization_done_in)
                frm <= {rx_dw1r_in, rx_dw2r_in};
            if (state == CHECK) begin
                status_q <= status_c;
                snap     <= {ok_cnt, err_cnt};
            end
            if (state == RESP) begin
                tx_dw1r_out  <= {frm.cmd | RESP_FLAG, frm.addr, resp_data[31:16]};
                tx_dw2r_out  <= {resp_data[15:0], frm.seq, status_q};
                tx_valid_out <= 1'b1;
                tmo_cnt      <= '0;
                if (status_q == ST_OK) ok_cnt  <= sat_inc(ok_cnt);
                else                   err_cnt <= sat_inc(err_cnt);
            end
            // A handshake on the terminal-count cycle still counts as delivered.
            if (state == TX_WAIT) begin
                if (tx_ready_in) begin
                    tx_valid_out <= 1'b0;
                end else if (tmo_hit) begin
                    tx_valid_out <= 1'b0;
                    err_cnt      <= sat_inc(err_cnt);
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
        end
    end

    assign rx_ready_out    = rdy_q;
    assign reg_addr_out    = frm.addr[ADDR_W-1:0];
    assign reg_wr_data_out = frm.data;
    assign ok_cnt_out      = ok_cnt;
    assign err_cnt_out     = err_cnt;
    assign busy_out        = (state != IDLE);

endmodule

// File: tb/tb_can_cmd_dispatcher.sv
// Directed scoreboard bench for can_cmd_dispatcher: responses and register
// strobes are queued at issue time and checked by independent monitors.
module tb_can_cmd_dispatcher;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        init_done;
    logic [31:0] rx_dw1, rx_dw2;
    logic        rx_valid, rx_ready;
    logic [31:0] tx_dw1, tx_dw2;
    logic        tx_valid, tx_ready;
    logic        wr_en, rd_en;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data = 32'h0;
    logic [15:0] ok_cnt, err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_resp[$];
    logic [36:0] sb_strb[$];

    always #5 sys_clk = ~sys_clk;

    can_cmd_dispatcher #(.NUM_REGS(8), .ADDR_W(3), .TX_TIMEOUT(16)) dut (
        .sys_clk                      (sys_clk),
        .reset_n                      (reset_n),
        .system_initilization_done_in (init_done),
        .rx_dw1r_in                   (rx_dw1),
        .rx_dw2r_in                   (rx_dw2),
        .rx_valid_in                  (rx_valid),
        .rx_ready_out                 (rx_ready),
        .tx_dw1r_out                  (tx_dw1),
        .tx_dw2r_out                  (tx_dw2),
        .tx_valid_out                 (tx_valid),
        .tx_ready_in                  (tx_ready),
        .reg_wr_en_out                (wr_en),
        .reg_rd_en_out                (rd_en),
        .reg_addr_out                 (addr),
        .reg_wr_data_out              (wr_data),
        .reg_rd_data_in               (rd_data),
        .ok_cnt_out                   (ok_cnt),
        .err_cnt_out                  (err_cnt),
        .busy_out                     (busy)
    );

    // Register-bus responder: read data appears one cycle after the strobe.
    always @(posedge sys_clk) rd_data <= rd_en ? 32'hDEADBEEF : 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor
    initial forever begin
        @(negedge sys_clk);
        if (reset_n && tx_valid && tx_ready) begin
            if (sb_resp.size() == 0) chk("unexpected_resp", {tx_dw1, tx_dw2}, 64'h0);
            else chk("resp", {tx_dw1, tx_dw2}, sb_resp.pop_front());
        end
    end

    // Register strobe monitor
    initial forever begin
        logic [36:0] act;
        @(negedge sys_clk);
        if (reset_n && (wr_en || rd_en)) begin
            act = {wr_en, rd_en, addr, wr_en ? wr_data : 32'h0};
            if (sb_strb.size() == 0) chk("unexpected_strobe", 64'(act), 64'h0);
            else chk("strobe", 64'(act), 64'(sb_strb.pop_front()));
        end
    end

    task automatic send(input logic [63:0] f);
        int n = 0;
        @(negedge sys_clk);
        rx_dw1   = f[63:32];
        rx_dw2   = f[31:0];
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 100) chk("rx_ready_wait", 64'(n), 64'h0);
        @(posedge sys_clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_tx(output int e);
        e = 0;
        while (!tx_valid && e < 20) begin
            @(posedge sys_clk);
            #1 e++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 200) chk("idle_wait", 64'(n), 64'h0);
    endtask

    task automatic xact(input logic [63:0] f, input logic [63:0] r,
                        input bit has_strb, input logic [36:0] s);
        int lat;
        sb_resp.push_back(r);
        if (has_strb) sb_strb.push_back(s);
        send(f);
        wait_tx(lat);
        chk("latency", 64'(lat), 64'd3);
        wait_idle();
    endtask

    task automatic tmo_xact(input logic [63:0] f, input logic [63:0] r, input logic [36:0] s);
        int lat, n;
        tx_ready = 1'b0;
        sb_strb.push_back(s);
        send(f);
        wait_tx(lat);
        chk("tmo_latency", 64'(lat), 64'd3);
        chk("tmo_data", {tx_dw1, tx_dw2}, r);
        n = 0;
        while (tx_valid && n < 100) begin
            @(posedge sys_clk);
            #1 n++;
        end
        chk("tmo_hold_cycles", 64'(n), 64'd16);
        chk("tmo_idle", {63'h0, busy}, 64'h0);
        tx_ready = 1'b1;
        wait_idle();
    endtask

    localparam logic [63:0] F1 = 64'h01020000_12340520, R1 = 64'h81020000_12340500;
    localparam logic [63:0] F2 = 64'h02020000_00000606, R2 = 64'h8202DEAD_BEEF0600;
    localparam logic [63:0] F3 = 64'h01020000_12340723, R3 = 64'h81020000_00000701;
    localparam logic [63:0] F4 = 64'h07010000_0000080E, R4 = 64'h87010000_00000803;
    localparam logic [63:0] F5 = 64'h0105AABB_CCDD0A0E, R5 = 64'h8105AABB_CCDD0A00;
    localparam logic [63:0] F6 = 64'h03000000_00000B08, R6 = 64'h83000003_00020B00;
    localparam logic [63:0] F7 = 64'h02080000_00000903, R7 = 64'h82080000_00000902;
    localparam logic [63:0] F8 = 64'h01010000_00010C0D, R8 = 64'h81010000_00010C00;
    localparam logic [63:0] F9 = 64'h03000000_00000D0E, R9 = 64'h83000005_00040D00;
    localparam logic [36:0] S1 = {2'b10, 3'd2, 32'h00001234};
    localparam logic [36:0] S2 = {2'b01, 3'd2, 32'h0};
    localparam logic [36:0] S5 = {2'b10, 3'd5, 32'hAABBCCDD};
    localparam logic [36:0] S8 = {2'b10, 3'd1, 32'h00000001};

    initial begin
        int lat;
        bit seen;
        reset_n = 1'b0; init_done = 1'b1; rx_valid = 1'b0;
        rx_dw1 = '0; rx_dw2 = '0; tx_ready = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("reset_ctrl", {59'h0, rx_ready, tx_valid, busy, wr_en, rd_en}, 64'h0);
        chk("reset_cnt", {32'h0, ok_cnt, err_cnt}, 64'h0);
        chk("reset_tx", {tx_dw1, tx_dw2}, 64'h0);
        reset_n = 1'b1;
        @(negedge sys_clk);
        chk("ready_after_reset", {63'h0, rx_ready}, 64'h1);

        xact(F1, R1, 1'b1, S1);  chk("ok_after_write", 64'(ok_cnt), 64'd1);
        xact(F2, R2, 1'b1, S2);  chk("ok_after_read", 64'(ok_cnt), 64'd2);
        xact(F3, R3, 1'b0, '0);  chk("err_after_csum", 64'(err_cnt), 64'd1);
        xact(F4, R4, 1'b0, '0);  chk("err_after_cmd", 64'(err_cnt), 64'd2);
        xact(F5, R5, 1'b1, S5);
        xact(F6, R6, 1'b0, '0);  chk("ok_after_status", 64'(ok_cnt), 64'd4);
        xact(F7, R7, 1'b0, '0);  chk("err_after_addr", 64'(err_cnt), 64'd3);

        tmo_xact(F8, R8, S8);
        chk("cnt_after_tmo", {32'h0, ok_cnt, err_cnt}, {32'h0, 16'd5, 16'd4});

        // init falling mid-transaction must not disturb it
        sb_resp.push_back(R9);
        send(F9);
        init_done = 1'b0;
        wait_tx(lat);
        chk("latency_init_drop", 64'(lat), 64'd3);
        wait_idle();
        init_done = 1'b1;

        @(negedge sys_clk);
        force dut.err_cnt = 16'hFFFF;
        @(negedge sys_clk);
        release dut.err_cnt;
        tmo_xact(F8, R8, S8);
        chk("err_sat_tmo", 64'(err_cnt), 64'hFFFF);
        xact(F4, R4, 1'b0, '0);
        chk("err_sat_resp", {32'h0, ok_cnt, err_cnt}, {32'h0, 16'd7, 16'hFFFF});

        init_done = 1'b0;
        send(F1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge sys_clk);
            if (tx_valid || busy) seen = 1'b1;
        end
        chk("noinit_quiet", {63'h0, seen}, 64'h0);
        chk("noinit_ready", {63'h0, rx_ready}, 64'h1);
        chk("noinit_cnt", 64'(ok_cnt), 64'd7);
        init_done = 1'b1;

        tx_ready = 1'b0;
        sb_strb.push_back(S1);
        send(F1);
        wait_tx(lat);
        chk("txwait_busy", {62'h0, busy, tx_valid}, 64'h3);
        @(negedge sys_clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset_ctrl", {59'h0, rx_ready, tx_valid, busy, wr_en, rd_en}, 64'h0);
        chk("async_reset_tx", {tx_dw1, tx_dw2}, 64'h0);
        chk("async_reset_cnt", {32'h0, ok_cnt, err_cnt}, 64'h0);
        tx_ready = 1'b1;
        @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);

        xact(F1, R1, 1'b1, S1);
        chk("ok_after_rereset", 64'(ok_cnt), 64'd1);

        repeat (3) @(negedge sys_clk);
        chk("resp_queue_empty", 64'(sb_resp.size()), 64'h0);
        chk("strobe_queue_empty", 64'(sb_strb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
